// File: rtl/limb_loader.sv
// Program-image writer: frames SYNC,N,4N data bytes,checksum into 32-bit words for instruction memory.
// Latency: one write strobe the cycle after each word's 4th byte; status one cycle after the checksum byte.
// Backpressure: byte_ready drops for the single write cycle per word; otherwise every offered byte is taken.
module limb_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         ADDR_WIDTH     = 8,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  prog_we,
    output logic [ADDR_WIDTH-1:0] prog_addr,
    output logic [31:0]           prog_data,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CSUM
    } state_t;

    state_t                state_q;
    logic                  byte_ready_q;
    logic                  prog_we_q;
    logic [ADDR_WIDTH-1:0] prog_addr_q;
    logic [31:0]           prog_data_q;
    logic                  cpu_hold_q;
    logic                  load_done_q;
    logic                  load_error_q;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [8:0]            words_left_q;
    logic [1:0]            byte_idx_q;
    logic [31:0]           word_q;
    logic [7:0]            sum_q;
    logic [TW-1:0]         idle_cnt_q;

    logic                  xfer;
    logic                  timeout_hit;
    logic [31:0]           word_d;
    logic [7:0]            sum_d;
    logic [TW-1:0]         idle_cnt_d;

    assign xfer        = byte_valid && byte_ready_q;
    assign timeout_hit = !xfer && (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign sum_d       = sum_q + byte_in;
    assign idle_cnt_d  = idle_cnt_q + TW'(1);

    // Merge the incoming byte into the word being assembled (little-endian lane order).
    always_comb begin
        word_d                      = word_q;
        word_d[8*byte_idx_q +: 8]   = byte_in;
    end

    // Frame parser, word writer, checksum and timeout supervision; all outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            byte_ready_q <= 1'b0;
            prog_we_q    <= 1'b0;
            prog_addr_q  <= '0;
            prog_data_q  <= '0;
            cpu_hold_q   <= 1'b0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            addr_q       <= '0;
            words_left_q <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            sum_q        <= '0;
            idle_cnt_q   <= '0;
        end else begin
            // The write strobe is a single-cycle pulse, only raised on entry to S_WRITE.
            prog_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    byte_ready_q <= 1'b1;
                    idle_cnt_q   <= '0;
                    if (xfer && (byte_in == SYNC_BYTE)) begin
                        cpu_hold_q   <= 1'b1;
                        load_done_q  <= 1'b0;
                        load_error_q <= 1'b0;
                        state_q      <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        // A length byte of zero encodes the full 256-word image.
                        words_left_q <= (byte_in == 8'd0) ? 9'd256 : {1'b0, byte_in};
                        addr_q       <= '0;
                        byte_idx_q   <= '0;
                        sum_q        <= '0;
                        idle_cnt_q   <= '0;
                        state_q      <= S_DATA;
                    end else if (timeout_hit) begin
                        load_error_q <= 1'b1;
                        idle_cnt_q   <= '0;
                        state_q      <= S_IDLE;
                    end else begin
                        idle_cnt_q <= idle_cnt_d;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        word_q     <= word_d;
                        sum_q      <= sum_d;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        idle_cnt_q <= '0;
                        if (byte_idx_q == 2'd3) begin
                            byte_ready_q <= 1'b0;
                            prog_we_q    <= 1'b1;
                            prog_addr_q  <= addr_q;
                            prog_data_q  <= word_d;
                            state_q      <= S_WRITE;
                        end
                    end else if (timeout_hit) begin
                        load_error_q <= 1'b1;
                        idle_cnt_q   <= '0;
                        state_q      <= S_IDLE;
                    end else begin
                        idle_cnt_q <= idle_cnt_d;
                    end
                end
                S_WRITE: begin
                    // Strobe cycle: the timeout counter is frozen and the next byte is held off.
                    byte_ready_q <= 1'b1;
                    addr_q       <= addr_q + ADDR_WIDTH'(1);
                    words_left_q <= words_left_q - 9'd1;
                    state_q      <= (words_left_q == 9'd1) ? S_CSUM : S_DATA;
                end
                S_CSUM: begin
                    if (xfer) begin
                        if (byte_in == sum_q) begin
                            load_done_q <= 1'b1;
                            cpu_hold_q  <= 1'b0;
                        end else begin
                            load_error_q <= 1'b1;
                        end
                        idle_cnt_q <= '0;
                        state_q    <= S_IDLE;
                    end else if (timeout_hit) begin
                        load_error_q <= 1'b1;
                        idle_cnt_q   <= '0;
                        state_q      <= S_IDLE;
                    end else begin
                        idle_cnt_q <= idle_cnt_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign byte_ready = byte_ready_q;
    assign prog_we    = prog_we_q;
    assign prog_addr  = prog_addr_q;
    assign prog_data  = prog_data_q;
    assign cpu_hold   = cpu_hold_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;

endmodule

// File: tb/tb_limb_loader.sv
// Bench for limb_loader: byte streams are driven through the handshake and compared against a frame-level model.
// Latency: status is checked a couple of cycles after the last byte of each stream.
// Backpressure: the driver holds a byte until byte_ready is seen, with optional random idle gaps.
module tb_limb_loader;

    localparam int AW      = 8;
    localparam int TIMEOUT = 1024;
    localparam logic [7:0] SYNC = 8'hA5;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_data;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]    stim_q[$];
    logic [AW-1:0] got_addr_q[$];
    logic [31:0]   got_data_q[$];
    int            exp_addr_q[$];
    logic [31:0]   exp_data_q[$];
    logic          m_done, m_err, m_hold;
    int            rdy_viol = 0;
    int            hold_viol = 0;
    int            both_viol = 0;

    limb_loader #(
        .SYNC_BYTE     (SYNC),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    // Write capture and invariant watch, sampled away from the active edge.
    always @(negedge clk) begin
        if (prog_we) begin
            got_addr_q.push_back(prog_addr);
            got_data_q.push_back(prog_data);
            if (byte_ready) rdy_viol++;
            if (!cpu_hold) hold_viol++;
        end
        if (load_done && load_error) both_viol++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: walk the byte stream, decode each frame, predict writes and status.
    task automatic model_stream();
        int i = 0;
        int words;
        int sum;
        logic [31:0] d;
        while (i < stim_q.size()) begin
            if (stim_q[i] != SYNC) begin
                i++;
                continue;
            end
            words = (stim_q[i+1] == 8'd0) ? 256 : int'(stim_q[i+1]);
            sum   = 0;
            for (int w = 0; w < words; w++) begin
                d = 32'd0;
                for (int b = 0; b < 4; b++) begin
                    d   = d | (32'(stim_q[i+2+4*w+b]) << (8*b));
                    sum = sum + int'(stim_q[i+2+4*w+b]);
                end
                exp_addr_q.push_back(w);
                exp_data_q.push_back(d);
            end
            if (int'(stim_q[i+2+4*words]) == (sum % 256)) begin
                m_done = 1'b1; m_err = 1'b0; m_hold = 1'b0;
            end else begin
                m_done = 1'b0; m_err = 1'b1; m_hold = 1'b1;
            end
            i = i + 3 + 4*words;
        end
    endtask

    // Called at a negedge; returns at the negedge following the transfer edge with byte_valid still high.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard = 0;
        if (gaps) begin
            byte_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("ready_wait", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic send_stream(input bit gaps);
        for (int k = 0; k < stim_q.size(); k++) send_byte(stim_q[k], gaps);
        byte_valid = 1'b0;
    endtask

    task automatic clear_queues();
        got_addr_q.delete();
        got_data_q.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic check_results(input string tag);
        check({tag, "_nwrites"}, 64'(got_addr_q.size()), 64'(exp_addr_q.size()));
        for (int i = 0; i < got_addr_q.size() && i < exp_addr_q.size(); i++) begin
            check({tag, "_addr"}, 64'(got_addr_q[i]), 64'(exp_addr_q[i]));
            check({tag, "_data"}, 64'(got_data_q[i]), 64'(exp_data_q[i]));
        end
        check({tag, "_done"}, 64'(load_done), 64'(m_done));
        check({tag, "_error"}, 64'(load_error), 64'(m_err));
        check({tag, "_hold"}, 64'(cpu_hold), 64'(m_hold));
        check({tag, "_rdy_in_write"}, 64'(rdy_viol), 64'd0);
        check({tag, "_nohold_in_write"}, 64'(hold_viol), 64'd0);
        check({tag, "_done_and_err"}, 64'(both_viol), 64'd0);
    endtask

    task automatic run_stream(input string tag, input bit gaps);
        clear_queues();
        model_stream();
        send_stream(gaps);
        repeat (3) @(negedge clk);
        check_results(tag);
    endtask

    task automatic add_good_example(input logic [7:0] csum);
        logic [7:0] fr [11];
        fr = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        fr[10] = csum;
        for (int k = 0; k < 11; k++) stim_q.push_back(fr[k]);
    endtask

    task automatic add_frame(input int n, input bit good, input bit pattern);
        int words;
        int s = 0;
        logic [7:0] b;
        words = (n == 0) ? 256 : n;
        stim_q.push_back(SYNC);
        stim_q.push_back(8'(n));
        for (int k = 0; k < 4*words; k++) begin
            b = pattern ? 8'(k) : 8'($urandom);
            stim_q.push_back(b);
            s = s + int'(b);
        end
        b = 8'(s);
        if (!good) b = b + 8'($urandom_range(1, 255));
        stim_q.push_back(b);
    endtask

    task automatic add_junk(input int cnt);
        logic [7:0] b;
        for (int k = 0; k < cnt; k++) begin
            b = 8'($urandom);
            if (b == SYNC) b = 8'h5A;
            stim_q.push_back(b);
        end
    endtask

    initial begin
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        m_done = 1'b0; m_err = 1'b0; m_hold = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(byte_ready), 64'd0);
        check("rst_we", 64'(prog_we), 64'd0);
        check("rst_addr", 64'(prog_addr), 64'd0);
        check("rst_data", 64'(prog_data), 64'd0);
        check("rst_hold", 64'(cpu_hold), 64'd0);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_error", 64'(load_error), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(byte_ready), 64'd1);

        // Reference frame with a good checksum.
        stim_q.delete();
        add_good_example(8'h64);
        run_stream("good", 1'b0);
        check("good_w0", 64'(got_data_q.size() > 0 ? got_data_q[0] : 32'hDEAD), 64'h44332211);
        check("good_w1", 64'(got_data_q.size() > 1 ? got_data_q[1] : 32'hDEAD), 64'h88776655);

        // Bad checksum, then a good frame clears the error and releases the core.
        stim_q.delete();
        add_good_example(8'h65);
        run_stream("badcsum", 1'b1);
        stim_q.delete();
        add_good_example(8'h64);
        run_stream("recover", 1'b1);

        // Leading junk is swallowed without touching the hold.
        stim_q.delete();
        stim_q.push_back(8'h00);
        stim_q.push_back(8'hFF);
        stim_q.push_back(8'h5A);
        run_stream("junk", 1'b0);
        stim_q.delete();
        add_good_example(8'h64);
        run_stream("after_junk", 1'b0);

        // Stall inside a word until the idle limit expires.
        clear_queues();
        stim_q.delete();
        stim_q.push_back(SYNC);
        stim_q.push_back(8'h01);
        stim_q.push_back(8'h11);
        send_stream(1'b0);
        repeat (TIMEOUT - 1) @(negedge clk);
        check("tmo_not_yet", 64'(load_error), 64'd0);
        check("tmo_hold_mid", 64'(cpu_hold), 64'd1);
        @(negedge clk);
        m_done = 1'b0; m_err = 1'b1; m_hold = 1'b1;
        check_results("timeout");
        check("tmo_ready", 64'(byte_ready), 64'd1);

        // Full 256-word image; address wrap after the last write must be invisible.
        stim_q.delete();
        add_frame(0, 1'b1, 1'b1);
        run_stream("full256", 1'b1);

        // Reset while the third data byte is on the bus with valid held high.
        stim_q.delete();
        stim_q.push_back(SYNC);
        stim_q.push_back(8'h02);
        stim_q.push_back(8'h11);
        stim_q.push_back(8'h22);
        clear_queues();
        for (int k = 0; k < stim_q.size(); k++) send_byte(stim_q[k], 1'b0);
        byte_in = 8'h33;
        reset   = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 64'(byte_ready), 64'd0);
        check("mid_rst_we", 64'(prog_we), 64'd0);
        check("mid_rst_addr", 64'(prog_addr), 64'd0);
        check("mid_rst_data", 64'(prog_data), 64'd0);
        check("mid_rst_hold", 64'(cpu_hold), 64'd0);
        check("mid_rst_done", 64'(load_done), 64'd0);
        check("mid_rst_error", 64'(load_error), 64'd0);
        check("mid_rst_nwrites", 64'(got_addr_q.size()), 64'd0);
        reset = 1'b0;
        m_done = 1'b0; m_err = 1'b0; m_hold = 1'b0;
        stim_q.delete();
        add_good_example(8'h64);
        run_stream("after_rst", 1'b0);

        // Randomized streams: junk, random lengths, random data (sync value included), mixed checksums.
        for (int it = 0; it < 6; it++) begin
            stim_q.delete();
            add_junk($urandom_range(0, 2));
            add_frame($urandom_range(1, 6), ($urandom_range(0, 3) != 0), 1'b0);
            if ($urandom_range(0, 1) == 1) add_frame($urandom_range(1, 4), ($urandom_range(0, 3) != 0), 1'b0);
            run_stream("random", 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
